counter_32_seq_ctrl: RTL and testbench
======================================

Name: counter_32_seq_ctrl

Overview:
Sequencing controller for one counter_32_rev instance. It drives the counter's s, Load and PData inputs and watches its cnt and Rc outputs. It turns a host start/stop handshake into one-shot or periodic interval runs in either direction, and reports expiries. It sits between the control FSM and the 32-bit up/down counter datapath.

Parameters:
CNT_W, 32, counter width; must match the counter instance.
EXP_W, 8, width of the saturating expiry counter.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-high.
start  in  1  begin a run; sampled in IDLE only.
stop  in  1  abort the current run; return to IDLE.
dir  in  1  direction latched at start: 1 = up, 0 = down.
periodic  in  1  latched at start: 1 = auto-reload on expiry, 0 = one-shot.
load_val  in  CNT_W  start value, latched at start.
cnt_in  in  CNT_W  counter cnt output.
rc_in  in  1  counter Rc output: high when cnt is all-ones (s=1) or zero (s=0).
cnt_s  out  1  drives counter s.
cnt_load  out  1  drives counter Load.
cnt_pdata  out  CNT_W  drives counter PData.
busy  out  1  high in LOAD and RUN.
done  out  1  one-cycle pulse when a one-shot run completes.
tick  out  1  one-cycle pulse for every expiry, both modes.
expire_cnt  out  EXP_W  expiries since the last start; saturates at all-ones.

Behaviour:
- States: IDLE, LOAD, RUN, DONE. Reset state is IDLE.
- Reset values: dir_q=0, periodic_q=0, val_q=0, hold_q=0, done=0, tick=0, expire_cnt=0, busy=0.
- Reset is asynchronous, so it takes effect mid-run with no completion pulses.
- cnt_load and cnt_pdata are combinational from the registered state and rc_in:
  - IDLE or DONE: cnt_load=1, cnt_pdata=hold_q. The counter is frozen at hold_q. During reset this loads 0 on every edge.
  - LOAD: cnt_load=1, cnt_pdata=val_q.
  - RUN: cnt_load = rc_in & periodic_q, cnt_pdata=val_q. Otherwise the counter counts freely.
- cnt_s = dir_q (registered).
- IDLE:
  - start=1 and stop=0: latch dir, periodic and load_val into dir_q, periodic_q, val_q; clear expire_cnt; go to LOAD.
  - start and stop in the same cycle: stop wins, stay in IDLE.
- LOAD: one cycle, then RUN. After this edge cnt_in equals val_q.
- RUN, evaluated in priority order:
  - stop=1: hold_q <= cnt_in; go to IDLE; no tick, no done.
  - rc_in=1 and periodic_q=1: the counter reloads val_q on the same edge with no wrap value visible. tick pulses next cycle, expire_cnt increments (saturating). Stay in RUN.
  - rc_in=1 and periodic_q=0: hold_q <= cnt_in (the terminal value); tick pulses, expire_cnt increments; go to DONE.
- DONE: done=1 for exactly this cycle, then IDLE.
- Period is |terminal − load_val| + 1 cycles. load_val equal to the terminal value gives an expiry every cycle (tick held high).
- start while busy or in DONE is ignored. dir, periodic and load_val changes during a run have no effect.
- expire_cnt holds its value in IDLE until the next accepted start.

Optional Feature:
Macro CTRL_PAUSE_EN adds input pause (1 bit).
- With macro defined: in RUN with pause=1 and stop=0, cnt_load=1 and cnt_pdata=cnt_in, so the counter holds its value.
  - rc_in is ignored while paused: no tick, no reload, no completion.
  - Counting resumes on the first cycle pause=0.
  - stop overrides pause.
- Without the macro: no pause port; behaviour is exactly as above.

Test Plan:
- Down one-shot: rst pulse; load_val=5, dir=0, periodic=0, start 1 cycle. Required: cnt_in 5,4,3,2,1,0, then held at 0; tick and done each pulse once; expire_cnt=1; busy low afterwards.
- Up periodic: load_val=32'hFFFFFFFD, dir=1, periodic=1. Required: cnt repeats FFFFFFFD, FFFFFFFE, FFFFFFFF with no 0 ever visible; tick every 3 cycles; expire_cnt=4 after 12 RUN cycles.
- Stop mid-run: down from 32'h10; assert stop when cnt=32'hA. Required: IDLE next cycle; cnt held at 32'hA; no done or tick.
- Start while busy: second start with load_val=7 during a run from 20. Required: ignored; run completes from 20; val_q unchanged.
- Reset mid-run: assert rst at cnt=3 of a down run. Required: outputs take reset values immediately; cnt loads 0 on the next edge; no done.
- Saturation and pause:
  - load_val=32'hFFFFFFFF up periodic for 300 cycles: expire_cnt=8'hFF.
  - With CTRL_PAUSE_EN, pause for 4 cycles at cnt=2 of a down run: cnt holds 2, then continues 1, 0.

Source files
------------

// File: rtl/counter_32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_32_seq_ctrl
//
// Sequencing controller for a single counter_32_rev instance. It converts a
// host start/stop handshake into one-shot or periodic interval runs, counting
// up or down. It also reports every expiry of the interval to the host.
//
// The controller drives the counter's s / Load / PData inputs and watches
// its cnt / Rc outputs. Whenever the controller is not running, it keeps
// the counter frozen by reloading a held value on every edge.
//
// Parameters:
//   CNT_W       counter width, must match the counter instance
//   EXP_W       width of the saturating expiry counter
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active-high
//   start       begin a run (accepted in IDLE only)
//   stop        abort the current run and return to IDLE
//   dir         direction latched at start: 1 = up, 0 = down
//   periodic    latched at start: 1 = auto-reload on expiry, 0 = one-shot
//   load_val    start value latched at start
//   pause       (CTRL_PAUSE_EN only) hold the counter while running
//   cnt_in      counter cnt output
//   rc_in       counter Rc output (terminal count for the current direction)
//   cnt_s       drives counter s
//   cnt_load    drives counter Load
//   cnt_pdata   drives counter PData
//   busy        high in LOAD and RUN
//   done        one-cycle pulse when a one-shot run completes
//   tick        one-cycle pulse for every expiry
//   expire_cnt  expiries since the last accepted start, saturating
//
// Optional feature macro: CTRL_PAUSE_EN adds the 'pause' input.
// ---------------------------------------------------------------------------
module counter_32_seq_ctrl #(
  parameter int CNT_W = 32,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
`ifdef CTRL_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             rc_in,
  output logic             cnt_s,
  output logic             cnt_load,
  output logic [CNT_W-1:0] cnt_pdata,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [EXP_W-1:0] expire_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic               periodic_q, periodic_d;
  logic [CNT_W-1:0]   val_q, val_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               tick_q, tick_d;
  logic [EXP_W-1:0]   expire_q, expire_d;
  logic               paused;

  // A pause only matters while running, and stop always takes priority.
`ifdef CTRL_PAUSE_EN
  assign paused = pause & ~stop & (state_q == RUN);
`else
  assign paused = 1'b0;
`endif

  // Next-state and next-output logic. The status outputs are registered, so
  // they are computed from the next state rather than the current one.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    periodic_d = periodic_q;
    val_d      = val_q;
    hold_d     = hold_q;
    tick_d     = 1'b0;
    expire_d   = expire_q;

    case (state_q)
      IDLE: begin
        // stop beats a simultaneous start
        if (start && !stop) begin
          dir_d      = dir;
          periodic_d = periodic;
          val_d      = load_val;
          expire_d   = '0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        state_d = RUN;
      end

      RUN: begin
        if (stop) begin
          // Freeze the counter where it stood when the host aborted.
          hold_d  = cnt_in;
          state_d = IDLE;
        end else if (rc_in && !paused) begin
          tick_d   = 1'b1;
          expire_d = (expire_q == '1) ? expire_q : expire_q + EXP_W'(1);
          if (!periodic_q) begin
            // The counter steps past the terminal value on this edge, so the
            // terminal value is captured here and reloaded from DONE on.
            hold_d  = cnt_in;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == LOAD) || (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // All controller state, including the registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      periodic_q <= 1'b0;
      val_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= 1'b0;
      expire_q   <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      periodic_q <= periodic_d;
      val_q      <= val_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tick_q     <= tick_d;
      expire_q   <= expire_d;
    end
  end

  // Counter load control. Outside a run the counter is pinned to hold_q;
  // during reset hold_q is zero, so the counter clears on every edge. In a
  // periodic run the reload happens on the expiry edge itself, which keeps
  // the wrap value from ever appearing on cnt_in.
  always_comb begin
    cnt_load  = 1'b1;
    cnt_pdata = hold_q;
    case (state_q)
      IDLE, DONE: begin
        cnt_load  = 1'b1;
        cnt_pdata = hold_q;
      end
      LOAD: begin
        cnt_load  = 1'b1;
        cnt_pdata = val_q;
      end
      RUN: begin
        if (paused) begin
          cnt_load  = 1'b1;
          cnt_pdata = cnt_in;
        end else begin
          cnt_load  = rc_in & periodic_q;
          cnt_pdata = val_q;
        end
      end
      default: begin
        cnt_load  = 1'b1;
        cnt_pdata = hold_q;
      end
    endcase
  end

  assign cnt_s      = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tick       = tick_q;
  assign expire_cnt = expire_q;

endmodule

// File: tb/tb_counter_32_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_32_seq_ctrl
//
// Directed bench for counter_32_seq_ctrl. A small behavioural model of the
// counter_32_rev datapath closes the loop around the controller. Expected
// counter values are queued when each run is launched and popped one per
// cycle as the counter produces them.
// ---------------------------------------------------------------------------
module tb_counter_32_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        stop;
   logic        dir;
   logic        periodic;
   logic [31:0] load_val;
`ifdef CTRL_PAUSE_EN
   logic        pause;
`endif
   logic [31:0] cntModel = '0;
   logic        rcModel;
   logic        cnt_s;
   logic        cnt_load;
   logic [31:0] cnt_pdata;
   logic        busy;
   logic        done;
   logic        tick;
   logic [7:0]  expire_cnt;

   int          checks = 0;
   int          errors = 0;
   int          tickSeen = 0;
   int          doneSeen = 0;
   logic [31:0] expQ[$];

   counter_32_seq_ctrl #(.CNT_W(32), .EXP_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .dir        (dir),
      .periodic   (periodic),
      .load_val   (load_val),
`ifdef CTRL_PAUSE_EN
      .pause      (pause),
`endif
      .cnt_in     (cntModel),
      .rc_in      (rcModel),
      .cnt_s      (cnt_s),
      .cnt_load   (cnt_load),
      .cnt_pdata  (cnt_pdata),
      .busy       (busy),
      .done       (done),
      .tick       (tick),
      .expire_cnt (expire_cnt)
   );

   // 10-unit clock period
   always #5 clk = ~clk;

   // Behavioural up/down counter with parallel load, as counter_32_rev.
   always @(posedge clk) begin
      if (cnt_load)
         cntModel <= cnt_pdata;
      else if (cnt_s)
         cntModel <= cntModel + 32'd1;
      else
         cntModel <= cntModel - 32'd1;
   end

   // Terminal-count flag for the current direction
   assign rcModel = cnt_s ? (&cntModel) : (cntModel == 32'd0);

   // Guard against a stuck run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next sampling point and record any pulses seen there.
   task automatic nextCycle();
      @(negedge clk);
      if (tick === 1'b1) tickSeen++;
      if (done === 1'b1) doneSeen++;
   endtask

   task automatic clearPulses();
      tickSeen = 0;
      doneSeen = 0;
   endtask

   // Present a start for one cycle; returns at the LOAD-state sample point.
   task automatic applyStimulus(input logic [31:0] val, input logic d, input logic p);
      start    = 1'b1;
      load_val = val;
      dir      = d;
      periodic = p;
      nextCycle();
      start    = 1'b0;
   endtask

   task automatic pushCount(input logic [31:0] first, input int n, input logic up);
      logic [31:0] v;
      v = first;
      for (int i = 0; i < n; i++) begin
         expQ.push_back(v);
         v = up ? v + 32'd1 : v - 32'd1;
      end
   endtask

   task automatic drainScoreboard(input string tag, input int n);
      logic [31:0] e;
      for (int i = 0; i < n; i++) begin
         nextCycle();
         if (expQ.size() == 0) begin
            checkOutput({tag, "_underflow"}, 32'd0, 32'd1);
         end else begin
            e = expQ.pop_front();
            checkOutput(tag, cntModel, e);
         end
      end
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      stop     = 1'b0;
      dir      = 1'b0;
      periodic = 1'b0;
      load_val = '0;
`ifdef CTRL_PAUSE_EN
      pause    = 1'b0;
`endif
      nextCycle();
      nextCycle();
      $display("[TB] reset state");
      checkOutput("rst_busy", busy, 1'b0);
      checkOutput("rst_done", done, 1'b0);
      checkOutput("rst_tick", tick, 1'b0);
      checkOutput("rst_expire", expire_cnt, 8'h00);
      checkOutput("rst_load", cnt_load, 1'b1);
      checkOutput("rst_pdata", cnt_pdata, 32'd0);
      checkOutput("rst_s", cnt_s, 1'b0);
      checkOutput("rst_cnt", cntModel, 32'd0);
      rst = 1'b0;
      nextCycle();

      $display("[TB] down one-shot from 5");
      clearPulses();
      applyStimulus(32'd5, 1'b0, 1'b0);
      checkOutput("os_load_busy", busy, 1'b1);
      checkOutput("os_load_ld", cnt_load, 1'b1);
      checkOutput("os_load_pdata", cnt_pdata, 32'd5);
      pushCount(32'd5, 6, 1'b0);
      drainScoreboard("os_cnt", 6);
      nextCycle();
      checkOutput("os_done_pulse", done, 1'b1);
      checkOutput("os_tick_pulse", tick, 1'b1);
      nextCycle();
      nextCycle();
      checkOutput("os_tick_count", tickSeen, 32'd1);
      checkOutput("os_done_count", doneSeen, 32'd1);
      checkOutput("os_expire", expire_cnt, 8'd1);
      checkOutput("os_busy_after", busy, 1'b0);
      checkOutput("os_cnt_held", cntModel, 32'd0);

      $display("[TB] up periodic from FFFFFFFD");
      clearPulses();
      applyStimulus(32'hFFFF_FFFD, 1'b1, 1'b1);
      checkOutput("per_s", cnt_s, 1'b1);
      for (int i = 0; i < 4; i++) pushCount(32'hFFFF_FFFD, 3, 1'b1);
      drainScoreboard("per_cnt", 12);
      nextCycle();
      checkOutput("per_expire", expire_cnt, 8'd4);
      checkOutput("per_reload", cntModel, 32'hFFFF_FFFD);
      checkOutput("per_tick_count", tickSeen, 32'd4);
      checkOutput("per_done_count", doneSeen, 32'd0);
      stop = 1'b1;
      nextCycle();
      stop = 1'b0;
      nextCycle();
      checkOutput("per_stop_busy", busy, 1'b0);
      checkOutput("per_expire_hold", expire_cnt, 8'd4);

      $display("[TB] stop mid-run");
      clearPulses();
      applyStimulus(32'h10, 1'b0, 1'b0);
      pushCount(32'h10, 7, 1'b0);
      drainScoreboard("stop_cnt", 7);
      stop = 1'b1;
      nextCycle();
      stop = 1'b0;
      checkOutput("stop_busy", busy, 1'b0);
      nextCycle();
      checkOutput("stop_cnt_held", cntModel, 32'hA);
      nextCycle();
      checkOutput("stop_cnt_held2", cntModel, 32'hA);
      checkOutput("stop_tick_count", tickSeen, 32'd0);
      checkOutput("stop_done_count", doneSeen, 32'd0);
      checkOutput("stop_expire", expire_cnt, 8'd0);

      $display("[TB] start with stop in the same cycle");
      start    = 1'b1;
      stop     = 1'b1;
      load_val = 32'd99;
      nextCycle();
      start = 1'b0;
      stop  = 1'b0;
      checkOutput("ss_busy", busy, 1'b0);
      checkOutput("ss_pdata", cnt_pdata, 32'hA);
      nextCycle();
      checkOutput("ss_cnt", cntModel, 32'hA);

      $display("[TB] start while busy");
      clearPulses();
      applyStimulus(32'd20, 1'b0, 1'b0);
      pushCount(32'd20, 21, 1'b0);
      drainScoreboard("busy_cnt", 3);
      start    = 1'b1;
      load_val = 32'd7;
      dir      = 1'b1;
      periodic = 1'b1;
      drainScoreboard("busy_cnt", 1);
      start = 1'b0;
      checkOutput("busy_val_kept", cnt_pdata, 32'd20);
      checkOutput("busy_dir_kept", cnt_s, 1'b0);
      drainScoreboard("busy_cnt", 17);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("busy_tick_count", tickSeen, 32'd1);
      checkOutput("busy_done_count", doneSeen, 32'd1);
      checkOutput("busy_expire", expire_cnt, 8'd1);
      checkOutput("busy_cnt_end", cntModel, 32'd0);

      $display("[TB] reset mid-run");
      clearPulses();
      applyStimulus(32'd8, 1'b0, 1'b0);
      pushCount(32'd8, 6, 1'b0);
      drainScoreboard("rmr_cnt", 6);
      checkOutput("rmr_busy_before", busy, 1'b1);
      rst = 1'b1;
      #1;
      checkOutput("rmr_busy", busy, 1'b0);
      checkOutput("rmr_done", done, 1'b0);
      checkOutput("rmr_tick", tick, 1'b0);
      checkOutput("rmr_expire", expire_cnt, 8'd0);
      checkOutput("rmr_load", cnt_load, 1'b1);
      checkOutput("rmr_pdata", cnt_pdata, 32'd0);
      nextCycle();
      checkOutput("rmr_cnt_zero", cntModel, 32'd0);
      rst = 1'b0;
      nextCycle();
      nextCycle();
      checkOutput("rmr_done_count", doneSeen, 32'd0);
      checkOutput("rmr_tick_count", tickSeen, 32'd0);
      checkOutput("rmr_cnt_held", cntModel, 32'd0);

      $display("[TB] expiry counter saturation");
      clearPulses();
      applyStimulus(32'hFFFF_FFFF, 1'b1, 1'b1);
      repeat (300) nextCycle();
      checkOutput("sat_expire", expire_cnt, 8'hFF);
      checkOutput("sat_tick_high", tick, 1'b1);
      checkOutput("sat_cnt", cntModel, 32'hFFFF_FFFF);
      checkOutput("sat_busy", busy, 1'b1);
      stop = 1'b1;
      nextCycle();
      stop = 1'b0;
      nextCycle();
      checkOutput("sat_hold_idle", expire_cnt, 8'hFF);
      checkOutput("sat_busy_after", busy, 1'b0);

      $display("[TB] down run with optional pause");
      clearPulses();
      applyStimulus(32'd5, 1'b0, 1'b0);
      checkOutput("pz_expire_clr", expire_cnt, 8'd0);
      pushCount(32'd5, 4, 1'b0);
      drainScoreboard("pz_cnt", 4);
`ifdef CTRL_PAUSE_EN
      pause = 1'b1;
      pushCount(32'd2, 1, 1'b0);
      pushCount(32'd2, 1, 1'b0);
      pushCount(32'd2, 1, 1'b0);
      pushCount(32'd2, 1, 1'b0);
      drainScoreboard("pz_hold", 4);
      pause = 1'b0;
      checkOutput("pz_no_tick", tickSeen, 32'd0);
`endif
      pushCount(32'd1, 2, 1'b0);
      drainScoreboard("pz_cnt", 2);
      nextCycle();
      nextCycle();
      nextCycle();
      checkOutput("pz_tick_count", tickSeen, 32'd1);
      checkOutput("pz_done_count", doneSeen, 32'd1);
      checkOutput("pz_expire", expire_cnt, 8'd1);
      checkOutput("pz_cnt_end", cntModel, 32'd0);
      checkOutput("sb_empty", expQ.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
